// File: rtl/dsp_pkg.sv
// Shared types and arithmetic helpers for the polyphase decimator.
package dsp_pkg;

    // Decimator control states.
    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fsm_e;

    // Full-precision accumulator width: product width plus growth over the tap sum.
    function automatic int unsigned acc_w(input int unsigned w, input int unsigned n);
        return 2 * w + $clog2(n);
    endfunction

    // Round half up by dropping frac bits, then saturate to a signed w-bit range.
    // Result is returned sign-extended to 64 bits; callers keep the low w bits.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int unsigned frac,
                                                     input int unsigned w);
        logic signed [63:0] rounded;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rounded = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (w - 1));
        if (rounded > hi) begin
            return hi;
        end else if (rounded < lo) begin
            return lo;
        end
        return rounded;
    endfunction

    // A decimation factor of 0 behaves as 1; anything above the maximum is pinned to it.
    function automatic int unsigned clamp_rate(input int unsigned r, input int unsigned mx);
        if (r == 0) begin
            return 1;
        end else if (r > mx) begin
            return mx;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_sat.sv
// Registered multiply-accumulate with clear-on-last, plus round and saturate of the final sum.
module mac_sat
    import dsp_pkg::*;
#(
    parameter int unsigned width     = 16,
    parameter int unsigned tap_len   = 21,
    parameter int unsigned coef_frac = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_last,
    input  logic [width-1:0] i_a,
    input  logic [width-1:0] i_b,
    output logic [width-1:0] o_y
);

    localparam int unsigned AccW = acc_w(width, tap_len);

    logic signed [2*width-1:0] w_prod;
    logic signed [AccW-1:0]    w_prod_x;
    logic signed [AccW-1:0]    w_sum;
    logic signed [63:0]        w_sum64;
    logic signed [AccW-1:0]    r_acc;

    assign w_prod   = $signed(i_a) * $signed(i_b);
    assign w_prod_x = {{(AccW - 2 * width){w_prod[2*width-1]}}, w_prod};
    // The last product of a channel is folded in here so the result is ready on the same edge.
    assign w_sum    = r_acc + w_prod_x;
    assign w_sum64  = {{(64 - AccW){w_sum[AccW-1]}}, w_sum};
    assign o_y      = width'(sat_round(w_sum64, coef_frac, width));

    // Accumulate while enabled; clear after the last tap so the next channel starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_last) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_sum;
            end
        end
    end

endmodule

// File: rtl/poly_deci_tdm.sv
// Multi-channel polyphase FIR decimator sharing one MAC across all channels and taps.
module poly_deci_tdm
    import dsp_pkg::*;
#(
    parameter int unsigned width     = 16,
    parameter int unsigned tap_len   = 21,
    parameter int unsigned ch        = 2,
    parameter int unsigned max_rate  = 8,
    parameter int unsigned coef_frac = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cke,
    input  logic [ch-1:0][width-1:0]          din,
    input  logic [$clog2(max_rate+1)-1:0]     rate,
    input  logic [tap_len-1:0][width-1:0]     tap,
    output logic [ch-1:0][width-1:0]          dout,
    output logic                              cke_out,
    output logic                              overrun
);

    localparam int unsigned RateW = $clog2(max_rate + 1);
    localparam int unsigned KiW   = (tap_len > 1) ? $clog2(tap_len) : 1;
    localparam int unsigned CiW   = (ch > 1) ? $clog2(ch) : 1;

    fsm_e r_state;
    fsm_e w_state_next;

    logic [width-1:0]        r_dly [ch][tap_len];
    logic [width-1:0]        r_shadow [ch];
    logic [ch-1:0][width-1:0] r_dout;
    logic [RateW-1:0]        r_phase;
    logic [RateW-1:0]        r_rate;
    logic [KiW-1:0]          r_ki;
    logic [CiW-1:0]          r_ci;
    logic                    r_cke_out;
    logic                    r_overrun;

    logic [RateW-1:0]        w_rate_cl;
    logic                    w_accept;
    logic                    w_dec;
    logic                    w_drop;
    logic                    w_last_k;
    logic                    w_last_c;
    logic                    w_mac_en;
    logic [width-1:0]        w_x;
    logic [width-1:0]        w_t;
    logic [width-1:0]        w_y;

    assign w_rate_cl = RateW'(clamp_rate(32'(rate), max_rate));
    assign w_last_k  = (r_ki == KiW'(tap_len - 1));
    assign w_last_c  = (r_ci == CiW'(ch - 1));
    assign w_mac_en  = (r_state == MAC);
    assign w_x       = r_dly[r_ci][r_ki];
    assign w_t       = tap[r_ki];

    assign dout    = r_dout;
    assign cke_out = r_cke_out;
    assign overrun = r_overrun;

    mac_sat #(
        .width     (width),
        .tap_len   (tap_len),
        .coef_frac (coef_frac)
    ) u_mac_sat (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_mac_en),
        .i_last (w_last_k),
        .i_a    (w_x),
        .i_b    (w_t),
        .o_y    (w_y)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle strobes: accept samples only in IDLE, flag drops otherwise.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_dec        = 1'b0;
        w_drop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cke) begin
                    w_accept = 1'b1;
                    if (r_phase == (r_rate - RateW'(1))) begin
                        w_dec        = 1'b1;
                        w_state_next = MAC;
                    end
                end
            end
            MAC: begin
                w_drop = cke;
                if (w_last_k && w_last_c) begin
                    w_state_next = OUT;
                end
            end
            OUT: begin
                w_drop       = cke;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Delay lines, phase and rate; a new rate is only picked up at a decimation boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < ch; c++) begin
                for (int k = 0; k < tap_len; k++) begin
                    r_dly[c][k] <= '0;
                end
            end
            r_phase <= '0;
            r_rate  <= w_rate_cl;
        end else if (w_accept) begin
            for (int c = 0; c < ch; c++) begin
                r_dly[c][0] <= din[c];
                for (int k = 1; k < tap_len; k++) begin
                    r_dly[c][k] <= r_dly[c][k-1];
                end
            end
            if (w_dec) begin
                r_phase <= '0;
                r_rate  <= w_rate_cl;
            end else begin
                r_phase <= r_phase + RateW'(1);
            end
        end
    end

    // MAC sequencing (channel-major) and per-channel result capture into the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ki <= '0;
            r_ci <= '0;
            for (int c = 0; c < ch; c++) begin
                r_shadow[c] <= '0;
            end
        end else if (r_state == MAC) begin
            if (w_last_k) begin
                r_ki           <= '0;
                r_shadow[r_ci] <= w_y;
                r_ci           <= w_last_c ? '0 : r_ci + CiW'(1);
            end else begin
                r_ki <= r_ki + KiW'(1);
            end
        end
    end

    // Output stage: all channels update together with a one-cycle strobe; overrun is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout    <= '0;
            r_cke_out <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cke_out <= (r_state == OUT);
            if (r_state == OUT) begin
                for (int c = 0; c < ch; c++) begin
                    r_dout[c] <= r_shadow[c];
                end
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule
